// File: rtl/dual_issue_scheduler.sv
// Dual-issue in-order scheduler at the consumer end of the decode FIFO.
// Optional SCHED_PERF_CNT_EN builds saturating dual/single/stall perf counters.
module dual_issue_scheduler #(
  parameter int INSTR_WIDTH = 64,
  parameter int NUM_REGS    = 32,
  parameter int REG_IDX_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] fifo_out1_i,
  input  logic [INSTR_WIDTH-1:0] fifo_out2_i,
  input  logic                   fifo_valid1_i,
  input  logic                   fifo_valid2_i,
  output logic                   dequeue_en_o,
  output logic [1:0]             dequeue_cnt_o,
  output logic                   stall_to_fifo_o,
  input  logic                   flush_i,
  output logic                   flush_o,
  input  logic [1:0]             issue_ready_i,
  output logic                   issue0_valid_o,
  output logic [INSTR_WIDTH-1:0] issue0_instr_o,
  output logic                   issue1_valid_o,
  output logic [INSTR_WIDTH-1:0] issue1_instr_o,
  input  logic [1:0]             wb_en_i,
  input  logic [REG_IDX_W-1:0]   wb_rd0_i,
  input  logic [REG_IDX_W-1:0]   wb_rd1_i,
  output logic [1:0]             sched_state_o,
  output logic [31:0]            perf_dual_o,
  output logic [31:0]            perf_single_o,
  output logic [31:0]            perf_stall_o
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, RECOVER = 2'd2} sched_state_e;

  sched_state_e           state_q, state_d;
  logic [NUM_REGS-1:0]    busy_q, busy_d, wb_clr, busy_eff, busy_set;
  logic                   iv0_q, iv0_d, iv1_q, iv1_d;
  logic [INSTR_WIDTH-1:0] ii0_q, ii0_d, ii1_q, ii1_d;
  logic                   run_ok, free0, free1, s0_go, s1_go, raw, waw;

  // Register busy check against the post-writeback view of the scoreboard.
  function automatic logic sb_ok(input logic [INSTR_WIDTH-1:0] ins,
                                 input logic [NUM_REGS-1:0] busy);
    logic [REG_IDX_W-1:0] rd, rs1, rs2;
    rd  = ins[4:0];
    rs1 = ins[9:5];
    rs2 = ins[14:10];
    return !busy[rs1] && !busy[rs2] && !(ins[15] && busy[rd]);
  endfunction

  logic [REG_IDX_W-1:0] h0_rd, h1_rd, h1_rs1, h1_rs2;
  logic                 h0_we, h1_we, h0_ser;
  logic [1:0]           h1_cls;
  assign h0_rd  = fifo_out1_i[4:0];
  assign h0_we  = fifo_out1_i[15];
  assign h0_ser = fifo_out1_i[18];
  assign h1_rd  = fifo_out2_i[4:0];
  assign h1_rs1 = fifo_out2_i[9:5];
  assign h1_rs2 = fifo_out2_i[14:10];
  assign h1_we  = fifo_out2_i[15];
  assign h1_cls = fifo_out2_i[17:16];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = RECOVER;
    else begin
      unique case (state_q)
        RUN:     if (s0_go && h0_ser) state_d = DRAIN;
        DRAIN:   if (busy_q == '0 && !iv0_q && !iv1_q) state_d = RUN;
        RECOVER: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    run_ok        = (state_q == RUN);
    sched_state_o = state_q;
  end

  always_comb begin
    wb_clr = '0;
    if (wb_en_i[0]) wb_clr[wb_rd0_i] = 1'b1;
    if (wb_en_i[1]) wb_clr[wb_rd1_i] = 1'b1;
  end
  assign busy_eff = busy_q & ~wb_clr;

  assign free0 = !iv0_q || issue_ready_i[0];
  assign free1 = !iv1_q || issue_ready_i[1];
  assign raw   = h0_we && (h0_rd != '0) && (h1_rs1 == h0_rd || h1_rs2 == h0_rd);
  assign waw   = h0_we && h1_we && (h0_rd == h1_rd);

  // rst gates issue so the pop count reads 0 while reset is held.
  assign s0_go = !rst && run_ok && !flush_i && fifo_valid1_i && free0 &&
                 sb_ok(fifo_out1_i, busy_eff);
  assign s1_go = s0_go && fifo_valid2_i && free1 && (h1_cls == 2'd0) && !h0_ser &&
                 !raw && !waw && sb_ok(fifo_out2_i, busy_eff);

  always_comb begin
    busy_set = '0;
    if (s0_go && h0_we) busy_set[h0_rd] = 1'b1;
    if (s1_go && h1_we) busy_set[h1_rd] = 1'b1;
    busy_d    = busy_eff | busy_set;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    iv0_d = iv0_q;
    ii0_d = ii0_q;
    iv1_d = iv1_q;
    ii1_d = ii1_q;
    if (flush_i) begin
      iv0_d = 1'b0;
      iv1_d = 1'b0;
    end else begin
      if (s0_go) begin
        iv0_d = 1'b1;
        ii0_d = fifo_out1_i;
      end else if (issue_ready_i[0]) iv0_d = 1'b0;
      if (s1_go) begin
        iv1_d = 1'b1;
        ii1_d = fifo_out2_i;
      end else if (issue_ready_i[1]) iv1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      iv0_q  <= 1'b0;
      iv1_q  <= 1'b0;
      ii0_q  <= '0;
      ii1_q  <= '0;
    end else begin
      busy_q <= busy_d;
      iv0_q  <= iv0_d;
      iv1_q  <= iv1_d;
      ii0_q  <= ii0_d;
      ii1_q  <= ii1_d;
    end
  end

  assign dequeue_cnt_o   = s1_go ? 2'd2 : (s0_go ? 2'd1 : 2'd0);
  assign dequeue_en_o    = (dequeue_cnt_o != 2'd0);
  assign flush_o         = flush_i;
  assign issue0_valid_o  = iv0_q;
  assign issue0_instr_o  = ii0_q;
  assign issue1_valid_o  = iv1_q;
  assign issue1_instr_o  = ii1_q;
  assign stall_to_fifo_o = iv0_q & ~issue_ready_i[0] & iv1_q & ~issue_ready_i[1];

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] pdual_q, pdual_d, psing_q, psing_d, pstall_q, pstall_d;

  always_comb begin
    pdual_d  = pdual_q;
    psing_d  = psing_q;
    pstall_d = pstall_q;
    if (dequeue_cnt_o == 2'd2 && pdual_q != 32'hFFFF_FFFF) pdual_d = pdual_q + 32'd1;
    if (dequeue_cnt_o == 2'd1 && psing_q != 32'hFFFF_FFFF) psing_d = psing_q + 32'd1;
    if (fifo_valid1_i && dequeue_cnt_o == 2'd0 && pstall_q != 32'hFFFF_FFFF)
      pstall_d = pstall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdual_q  <= '0;
      psing_q  <= '0;
      pstall_q <= '0;
    end else begin
      pdual_q  <= pdual_d;
      psing_q  <= psing_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_dual_o   = pdual_q;
  assign perf_single_o = psing_q;
  assign perf_stall_o  = pstall_q;
`else
  assign perf_dual_o   = '0;
  assign perf_single_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Consumer end of the decode-to-scheduler instruction FIFO. Each cycle it inspects the FIFO's two head entries and checks them against a register scoreboard and pairing rules. It issues 0, 1 or 2 instructions in order to two execution pipes, then tells the FIFO how many entries to pop. It also forwards pipeline flush and backpressure to the FIFO.

Parameters:
INSTR_WIDTH, 64, width of one decoded instruction bundle
NUM_REGS, 32, architectural registers tracked by the scoreboard
REG_IDX_W, 5, register index width (log2 NUM_REGS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
fifo_out1_i  in  INSTR_WIDTH  FIFO head entry (oldest)
fifo_out2_i  in  INSTR_WIDTH  FIFO head+1 entry
fifo_valid1_i  in  1  head entry valid
fifo_valid2_i  in  1  head+1 entry valid
dequeue_en_o  in→out  1  output; pop request, equals (dequeue_cnt_o != 0)
dequeue_cnt_o  out  2  entries popped this cycle (0/1/2)
stall_to_fifo_o  out  1  both issue registers are held (pipes not ready)
flush_i  in  1  redirect from execute; kills younger work
flush_o  out  1  flush to FIFO, combinational copy of flush_i
issue_ready_i  in  2  bit0 = pipe0 ready, bit1 = pipe1 ready
issue0_valid_o  out  1  pipe0 issue valid
issue0_instr_o  out  INSTR_WIDTH  pipe0 instruction
issue1_valid_o  out  1  pipe1 issue valid
issue1_instr_o  out  INSTR_WIDTH  pipe1 instruction
wb_en_i  in  2  writeback strobes, one per pipe
wb_rd0_i  in  REG_IDX_W  pipe0 writeback register
wb_rd1_i  in  REG_IDX_W  pipe1 writeback register
sched_state_o  out  2  FSM state (RUN=0, DRAIN=1, RECOVER=2)
perf_dual_o, perf_single_o, perf_stall_o  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Instruction fields: [4:0] rd, [9:5] rs1, [14:10] rs2, [15] rd_we, [17:16] class (0 ALU, 1 MUL, 2 LSU, 3 BR), [18] serialize. All other bits are opaque and passed through unchanged.
- Reset (rst high, async): all issue valids 0, issue instrs 0, scoreboard all clear, FSM RUN, dequeue_cnt_o 0, perf counters 0.
- Scoreboard: one busy bit per register; bit 0 is never set.
  - Set on issue when rd_we=1 and rd!=0.
  - Cleared on wb_en_i[k] for wb_rdk_i.
  - Set and clear of the same register in the same cycle: set wins.
- Issue registers use valid/ready per pipe. An issue register is "free" if it is invalid or its ready is high this cycle. A held register keeps valid and instr stable.
- Slot0 (head) issues when all of the following hold:
  - FSM is RUN, flush_i=0, fifo_valid1_i=1, pipe0 register free;
  - rs1, rs2 and rd (if rd_we) are not busy;
  - a writeback clearing the bit in the same cycle counts as not busy.
- Slot1 (head+1) issues only when all of the following hold:
  - slot0 issues and fifo_valid2_i=1;
  - pipe1 register free;
  - class is ALU, and slot0 serialize=0;
  - no RAW: rs1/rs2 differ from slot0 rd when slot0 rd_we=1 and rd!=0;
  - no WAW with slot0 on the same rd;
  - its own scoreboard check passes.
- Slot1 never issues without slot0; order is always preserved.
- Latency: FIFO head visible in cycle N → issue valid from cycle N+1; the pop takes effect in cycle N.
- dequeue_cnt_o = number issued in the cycle; combinational from the inputs and current state.
- FSM:
  - RUN → DRAIN when an instruction with serialize=1 issues in slot0.
  - DRAIN: no issue. → RUN when the scoreboard is all clear and both issue valids are 0.
  - Any state → RECOVER on flush_i.
  - RECOVER: 1 cycle, no issue, then → RUN.
- Flush: on the cycle flush_i=1, issue valids are cleared at the next edge, dequeue_cnt_o=0, and flush_o=1. Scoreboard bits are kept; older in-flight writebacks clear them.
- stall_to_fifo_o = issue0_valid_o & ~issue_ready_i[0] & issue1_valid_o & ~issue_ready_i[1].

Optional Feature:
SCHED_PERF_CNT_EN defined:
- perf_dual_o increments on cycles with dequeue_cnt_o=2.
- perf_single_o increments on cycles with dequeue_cnt_o=1.
- perf_stall_o increments on cycles with fifo_valid1_i=1 and dequeue_cnt_o=0.
- All three saturate at 32'hFFFFFFFF and are cleared by rst only; flush does not clear them.
Undefined: all three outputs are tied to 0 and no counter flops are built.

Test Plan:
- Two independent ALU ops (rd=1, rd=2), both valid, both ready → dequeue_cnt_o=2 in cycle N; both issue valids high in N+1; scoreboard bits 1 and 2 set.
- Head writes r3, head+1 reads r3 → cnt=1, only pipe0 issues. Next cycle the new head (former head+1) waits until wb_en_i[0] with wb_rd0_i=3, then issues.
- Head is MUL and head+1 is LSU → single issue; head+1 issues alone on the following cycle via pipe0.
- Serialize BR issued → FSM DRAIN (sched_state_o=1) and cnt=0 until the scoreboard is clear and the issue valids drop, then RUN.
- issue_ready_i=2'b00 with both registers valid → stall_to_fifo_o=1, cnt=0, and instrs held stable for 3 cycles. flush_i pulse → valids 0 next cycle, then RECOVER for 1 cycle, then RUN.
- With SCHED_PERF_CNT_EN: 5 dual-issue cycles, 3 single-issue cycles, 2 blocked cycles → perf counters read 5/3/2. rst mid-run → all outputs return to reset values asynchronously.
